sequence_event_monitor: RTL and testbench

- Downstream stage of the 4-in-a-row sequence detector (detects 0000 or 1111).
- Consumes the detector output z and the observed bit w.
- Counts distinct detection events, tracks the current and longest run of consecutive z=1 cycles, and drives board LEDs and HEX displays.
- Board-level pin naming.

---
 rtl/sequence_event_monitor_pkg.sv | 33 +++
 rtl/hex_to_7seg.sv | 32 +++
 rtl/sequence_event_monitor.sv | 111 +++++++++++
 tb/tb_sequence_event_monitor.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/sequence_event_monitor_pkg.sv
// Shared definitions for sequence_event_monitor: FSM state encoding and
// active-low seven-segment patterns.
package sequence_event_monitor_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DETECT = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;

  typedef enum logic [1:0] {
    StIdle   = IDLE,
    StDetect = DETECT,
    StHold   = HOLD
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
module hex_to_7seg
  import sequence_event_monitor_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nib)
      4'h0:    o_seg = SEG_0;
      4'h1:    o_seg = SEG_1;
      4'h2:    o_seg = SEG_2;
      4'h3:    o_seg = SEG_3;
      4'h4:    o_seg = SEG_4;
      4'h5:    o_seg = SEG_5;
      4'h6:    o_seg = SEG_6;
      4'h7:    o_seg = SEG_7;
      4'h8:    o_seg = SEG_8;
      4'h9:    o_seg = SEG_9;
      4'hA:    o_seg = SEG_A;
      4'hB:    o_seg = SEG_B;
      4'hC:    o_seg = SEG_C;
      4'hD:    o_seg = SEG_D;
      4'hE:    o_seg = SEG_E;
      4'hF:    o_seg = SEG_F;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/sequence_event_monitor.sv
// Counts z detection events and tracks current/longest z=1 runs for board display.
// Optional macro SEQ_MONITOR_PARITY_EN puts running parity of w on LEDR[8].
module sequence_event_monitor
  import sequence_event_monitor_pkg::*;
#(
  parameter int unsigned CNT_W = 8,  // must be >= 8 (LEDR[7:0] shows low byte)
  parameter int unsigned RUN_W = 8   // must be >= 8 (HEX1:HEX0 show low byte)
) (
  input  logic [0:0] KEY,
  input  logic [1:0] SW,
  input  logic       z,
  output logic [9:0] LEDR,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1
);

  localparam logic [RUN_W-1:0] RunMax = '1;

  logic             w_clk;
  logic             w_rst_n;
  logic             w_event;
  logic             w_led8;
  logic [RUN_W-1:0] w_run_nxt;

  state_e           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ovf;
  logic             r_z;
  logic [RUN_W-1:0] r_run;
  logic [RUN_W-1:0] r_longest;

  assign w_clk   = KEY[0];
  assign w_rst_n = SW[0];
  assign w_event = z && (r_state == StIdle);

  always_comb begin
    w_run_nxt = '0;
    if (z) begin
      if (r_state == StIdle) begin
        w_run_nxt = RUN_W'(1);
      end else if (r_run != RunMax) begin
        w_run_nxt = r_run + 1'b1;
      end else begin
        w_run_nxt = r_run;
      end
    end
  end

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_z       <= 1'b0;
      r_run     <= '0;
      r_longest <= '0;
    end else begin
      r_z <= z;
      case (r_state)
        StIdle:   if (z) r_state <= StDetect;
        StDetect: r_state <= z ? StHold : StIdle;
        StHold:   if (!z) r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
      if (w_event) begin
        r_cnt <= r_cnt + 1'b1;
        if (&r_cnt) r_ovf <= 1'b1;
      end
      r_run <= w_run_nxt;
      if (w_run_nxt > r_longest) r_longest <= w_run_nxt;
    end
  end

`ifdef SEQ_MONITOR_PARITY_EN
  logic r_par;
  logic w_unused_ovf;

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) r_par <= 1'b0;
    else          r_par <= r_par ^ SW[1];
  end

  // Overflow is kept for internal bookkeeping only in this build.
  assign w_unused_ovf = r_ovf;
  assign w_led8       = r_par;
`else
  logic r_w;
  logic w_unused_w;

  always_ff @(posedge w_clk) begin
    if (!w_rst_n) r_w <= 1'b0;
    else          r_w <= SW[1];
  end

  assign w_unused_w = r_w;
  assign w_led8     = r_ovf;
`endif

  assign LEDR = {r_z, w_led8, r_cnt[7:0]};

  hex_to_7seg u_hex0 (
    .i_nib (r_longest[3:0]),
    .o_seg (HEX0)
  );

  hex_to_7seg u_hex1 (
    .i_nib (r_longest[7:4]),
    .o_seg (HEX1)
  );

endmodule

// File: tb/tb_sequence_event_monitor.sv
// Directed self-checking bench for sequence_event_monitor (default parameters).
module tb_sequence_event_monitor;

`ifdef SEQ_MONITOR_PARITY_EN
  localparam bit Par = 1'b1;
`else
  localparam bit Par = 1'b0;
`endif

  logic [0:0] KEY;
  logic [1:0] SW;
  logic       z;
  logic [9:0] LEDR;
  logic [6:0] HEX0;
  logic [6:0] HEX1;

  int total = 0;
  int bad   = 0;

  sequence_event_monitor #(
    .CNT_W (8),
    .RUN_W (8)
  ) dut (
    .KEY  (KEY),
    .SW   (SW),
    .z    (z),
    .LEDR (LEDR),
    .HEX0 (HEX0),
    .HEX1 (HEX1)
  );

  initial KEY = 1'b0;
  always #5 KEY = ~KEY;

  // Apply inputs, take one rising edge, then settle 1 time unit past it.
  task automatic step(input logic zv, input logic wv, input logic rstn);
    z  = zv;
    SW = {wv, rstn};
    @(posedge KEY[0]);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    z  = 1'b0;
    SW = 2'b00;

    // Reset
    do_reset();
    chk("reset_ledr", LEDR, 10'h000);
    chk("reset_hex0", {3'b0, HEX0}, 10'h040);
    chk("reset_hex1", {3'b0, HEX1}, 10'h040);

    // Single-cycle detection
    step(1'b1, 1'b0, 1'b1);
    chk("single_ledr", LEDR, 10'h201);
    chk("single_hex0", {3'b0, HEX0}, 10'h079);
    step(1'b0, 1'b0, 1'b1);
    chk("single_fall_ledr", LEDR, 10'h001);

    // Long run of 6
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    chk("long_mid_hex0", {3'b0, HEX0}, 10'h030);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    chk("long_ledr", LEDR, 10'h201);
    chk("long_hex0", {3'b0, HEX0}, 10'h002);
    chk("long_hex1", {3'b0, HEX1}, 10'h040);
    step(1'b0, 1'b0, 1'b1);
    chk("long_fall_ledr", LEDR, 10'h001);
    chk("long_fall_hex0", {3'b0, HEX0}, 10'h002);

    // Gap: 3 high, 1 low, 2 high
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b1);
    chk("gap_ledr", LEDR, 10'h202);
    chk("gap_hex0", {3'b0, HEX0}, 10'h030);

    // Run of 18 exercises the high nibble
    do_reset();
    for (int i = 0; i < 18; i++) step(1'b1, 1'b0, 1'b1);
    chk("run18_hex0", {3'b0, HEX0}, 10'h024);
    chk("run18_hex1", {3'b0, HEX1}, 10'h079);

    // Run saturation at 255, longest never decreases
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 1'b1);
    chk("sat_ledr", LEDR, 10'h201);
    chk("sat_hex0", {3'b0, HEX0}, 10'h00E);
    chk("sat_hex1", {3'b0, HEX1}, 10'h00E);
    step(1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    chk("sat_again_ledr", LEDR, 10'h202);
    chk("sat_again_hex0", {3'b0, HEX0}, 10'h00E);

    // Event count wrap and sticky overflow
    do_reset();
    for (int i = 0; i < 255; i++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
    end
    chk("wrap_255_ledr", LEDR, 10'h0FF);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("wrap_ledr", LEDR, Par ? 10'h000 : 10'h100);
    chk("wrap_hex0", {3'b0, HEX0}, 10'h079);
    step(1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("ovf_sticky_ledr", LEDR, Par ? 10'h001 : 10'h101);

    // Mid-run reset with z held high
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    chk("midrst_pre_ledr", LEDR, 10'h201);
    chk("midrst_pre_hex0", {3'b0, HEX0}, 10'h012);
    step(1'b1, 1'b0, 1'b0);
    chk("midrst_in_ledr", LEDR, 10'h000);
    chk("midrst_in_hex0", {3'b0, HEX0}, 10'h040);
    step(1'b1, 1'b0, 1'b1);
    chk("midrst_post_ledr", LEDR, 10'h201);
    chk("midrst_post_hex0", {3'b0, HEX0}, 10'h079);

    // w stream 1,1,1 then one more 1
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);
    chk("par3_ledr", LEDR, Par ? 10'h100 : 10'h000);
    step(1'b0, 1'b1, 1'b1);
    chk("par4_ledr", LEDR, 10'h000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
